// File: rtl/ibex_vec_pkg.sv
// Shared types and helpers for the vector register-file write sequencer.
// Encodings match the vsew/vlmul fields of the vtype CSR.
package ibex_vec_pkg;

    localparam int unsigned VLEN_DEFAULT = 32;

    typedef enum logic [2:0] {
        SEW_8  = 3'b000,
        SEW_16 = 3'b001,
        SEW_32 = 3'b010
    } sew_e;

    typedef enum logic [2:0] {
        LMUL_1 = 3'b000,
        LMUL_2 = 3'b001,
        LMUL_4 = 3'b010
    } lmul_e;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_FINISH = 2'd2
    } state_e;

    function automatic logic [2:0] sew_bytes(input sew_e sew);
        case (sew)
            SEW_16:  return 3'd2;
            SEW_32:  return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    function automatic logic [2:0] lmul_regs(input lmul_e lmul);
        case (lmul)
            LMUL_2:  return 3'd2;
            LMUL_4:  return 3'd4;
            default: return 3'd1;
        endcase
    endfunction

    // Elements that fit in a register group: VLEN * LMUL / SEW.
    function automatic int unsigned vlmax(input int unsigned vlen, input sew_e sew,
                                          input lmul_e lmul);
        return (vlen * {29'd0, lmul_regs(lmul)}) / (32'd8 * {29'd0, sew_bytes(sew)});
    endfunction

endpackage

// File: rtl/ibex_vec_elem_packer.sv
// Packs SEW-wide elements into 32-bit words and tracks which byte lanes hold data.
// A word is released when lane 3 fills or when the final element of the operation arrives.
module ibex_vec_elem_packer
    import ibex_vec_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        clear_i,
    input  logic        accept_i,
    input  logic        last_i,
    input  sew_e        sew_i,
    input  logic [1:0]  byte_off_i,
    input  logic [31:0] elem_data_i,
    output logic        flush_o,
    output logic [31:0] word_data_o,
    output logic [3:0]  word_be_o
);

    logic [31:0] acc_data_q;
    logic [3:0]  acc_be_q;
    logic [31:0] elem_mask;
    logic [3:0]  lane_mask;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        elem_mask = 32'h0000_00ff;
        lane_mask = 4'b0001;
        case (sew_i)
            SEW_16: begin
                elem_mask = 32'h0000_ffff;
                lane_mask = 4'b0011;
            end
            SEW_32: begin
                elem_mask = 32'hffff_ffff;
                lane_mask = 4'b1111;
            end
            default: ;
        endcase
        // Unused upper element bits are masked off so disabled lanes stay zero.
        word_data_o = acc_data_q | ((elem_data_i & elem_mask) << {byte_off_i, 3'b000});
        word_be_o   = acc_be_q | (lane_mask << byte_off_i);
        flush_o     = accept_i && (last_i || word_be_o[3]);
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            acc_data_q <= '0;
            acc_be_q   <= '0;
        end else if (clear_i || flush_o) begin
            acc_data_q <= '0;
            acc_be_q   <= '0;
        end else if (accept_i) begin
            acc_data_q <= word_data_o;
            acc_be_q   <= word_be_o;
        end
    end

endmodule

// File: rtl/ibex_vrf_write_seq.sv
// Vector register-file write sequencer: validates a vtype-like request, accepts an element
// stream and emits packed, byte-enabled word writes to vd, vd+1, ...
module ibex_vrf_write_seq
    import ibex_vec_pkg::*;
#(
    parameter int unsigned VLEN      = VLEN_DEFAULT,
    parameter int unsigned VLMUL_MAX = 4
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        start_i,
    input  logic [3:0]  vd_i,
    input  logic [2:0]  vsew_i,
    input  logic [2:0]  vlmul_i,
    input  logic [4:0]  vl_i,
    input  logic        elem_valid_i,
    input  logic [31:0] elem_data_i,
    output logic        elem_ready_o,
    output logic        we_o,
    output logic [3:0]  waddr_o,
    output logic [31:0] wdata_o,
    output logic [3:0]  wbe_o,
    output logic        busy_o,
    output logic        done_o,
    output logic        err_o
);

    state_e      state_q, state_d;
    logic [3:0]  vd_q;
    sew_e        sew_q;
    logic [4:0]  vl_q;
    logic [4:0]  elem_cnt_q;
    logic [1:0]  byte_off_q;
    logic [3:0]  word_idx_q;
    logic        we_q, err_q, zero_done_q;
    logic [3:0]  waddr_q, wbe_q;
    logic [31:0] wdata_q;

    logic        start_legal, start_ok, start_bad;
    logic [4:0]  grp_regs;
    int unsigned vlmax_n;
    logic        accept, last_elem, flush;
    logic [2:0]  off_sum;
    logic [31:0] pack_data;
    logic [3:0]  pack_be;

    always_comb begin
        grp_regs    = 5'd1 << vlmul_i[1:0];
        vlmax_n     = vlmax(VLEN, sew_e'(vsew_i), lmul_e'(vlmul_i));
        start_legal = (vsew_i <= 3'b010) && (vlmul_i <= 3'b010)
                   && ({27'd0, grp_regs} <= VLMUL_MAX)
                   && ({27'd0, vl_i} <= vlmax_n)
                   && ((vd_i & (grp_regs[3:0] - 4'd1)) == 4'd0)
                   && (({1'b0, vd_i} + grp_regs) <= 5'd16);
        start_ok    = (state_q == ST_IDLE) && start_i && start_legal;
        start_bad   = (state_q == ST_IDLE) && start_i && !start_legal;
        accept      = (state_q == ST_ACTIVE) && elem_valid_i;
        last_elem   = (elem_cnt_q == vl_q - 5'd1);
        off_sum     = {1'b0, byte_off_q} + sew_bytes(sew_q);
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (start_ok && (vl_i != 5'd0)) state_d = ST_ACTIVE;
            ST_ACTIVE: if (accept && last_elem) state_d = ST_FINISH;
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    ibex_vec_elem_packer u_packer (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clear_i     (start_ok),
        .accept_i    (accept),
        .last_i      (last_elem),
        .sew_i       (sew_q),
        .byte_off_i  (byte_off_q),
        .elem_data_i (elem_data_i),
        .flush_o     (flush),
        .word_data_o (pack_data),
        .word_be_o   (pack_be)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vd_q        <= '0;
            sew_q       <= SEW_8;
            vl_q        <= '0;
            elem_cnt_q  <= '0;
            byte_off_q  <= '0;
            word_idx_q  <= '0;
            we_q        <= 1'b0;
            waddr_q     <= '0;
            wdata_q     <= '0;
            wbe_q       <= '0;
            err_q       <= 1'b0;
            zero_done_q <= 1'b0;
        end else begin
            err_q       <= start_bad;
            zero_done_q <= start_ok && (vl_i == 5'd0);
            // Write port is zero whenever no write is issued.
            we_q        <= flush;
            waddr_q     <= flush ? vd_q + word_idx_q : '0;
            wdata_q     <= flush ? pack_data : '0;
            wbe_q       <= flush ? pack_be : '0;
            if (start_ok) begin
                vd_q       <= vd_i;
                sew_q      <= sew_e'(vsew_i);
                vl_q       <= vl_i;
                elem_cnt_q <= '0;
                byte_off_q <= '0;
                word_idx_q <= '0;
            end else if (accept) begin
                elem_cnt_q <= elem_cnt_q + 5'd1;
                byte_off_q <= off_sum[1:0];
                word_idx_q <= word_idx_q + {3'd0, off_sum[2]};
            end
        end
    end

    assign elem_ready_o = (state_q == ST_ACTIVE);
    assign busy_o       = (state_q != ST_IDLE);
    assign done_o       = (state_q == ST_FINISH) || zero_done_q;
    assign err_o        = err_q;
    assign we_o         = we_q;
    assign waddr_o      = waddr_q;
    assign wdata_o      = wdata_q;
    assign wbe_o        = wbe_q;

endmodule
